// File: rtl/imm_encoder.sv
// RV32I instruction encoder: packs I/S/B/J fields with immediate range and
// alignment checks, and expands the LI pseudo-op into ADDI or LUI(+ADDI).
module imm_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [1:0]  out_err,
  output logic [1:0]  state_dbg
);

  // Handshake: a beat moves on either side only at a rising clk edge where
  // valid and ready are both 1; valid never depends on ready, and out_inst /
  // out_err hold stable while out_valid is 1 and out_ready is 0.

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] FULL  = 2'd1;
  localparam logic [1:0] FULL2 = 2'd2;

  localparam logic [2:0] FMT_I  = 3'd0;
  localparam logic [2:0] FMT_S  = 3'd1;
  localparam logic [2:0] FMT_B  = 3'd2;
  localparam logic [2:0] FMT_J  = 3'd3;
  localparam logic [2:0] FMT_LI = 3'd4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [1:0]  state;
  logic        accept;

  logic [31:0] pack_inst;
  logic [31:0] enc_inst;
  logic [1:0]  enc_err;
  logic        enc_two;
  logic [19:0] lui_hi;
  logic        op_ok;
  logic        fit12;
  logic        fit_b;
  logic        fit_j;

  logic [4:0]  pend_rd;
  logic [11:0] pend_imm;

  assign in_ready  = (state == EMPTY) | ((state == FULL) & out_ready);
  assign accept    = in_valid & in_ready;
  assign state_dbg = state;

  // Rounding the upper part by imm[11] compensates for ADDI sign-extending
  // its 12-bit immediate.
  assign lui_hi = in_imm[31:12] + {19'd0, in_imm[11]};

  assign op_ok = (in_opcode == OP_LOAD) | (in_opcode == OP_IMM) |
                 (in_opcode == OP_JALR);
  assign fit12 = ($signed(in_imm) >= -32'sd2048)    & ($signed(in_imm) <= 32'sd2047);
  assign fit_b = ($signed(in_imm) >= -32'sd4096)    & ($signed(in_imm) <= 32'sd4094);
  assign fit_j = ($signed(in_imm) >= -32'sd1048576) & ($signed(in_imm) <= 32'sd1048574);

  always_comb begin
    pack_inst = NOP;
    enc_err   = 2'b00;
    enc_two   = 1'b0;
    case (in_fmt)
      FMT_I: begin
        pack_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        if (!op_ok)      enc_err = 2'b11;
        else if (!fit12) enc_err = 2'b01;
      end
      FMT_S: begin
        pack_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
        if (!fit12) enc_err = 2'b01;
      end
      FMT_B: begin
        pack_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], OP_BRANCH};
        enc_err   = {in_imm[0], ~fit_b};
      end
      FMT_J: begin
        pack_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
        enc_err   = {in_imm[0], ~fit_j};
      end
      FMT_LI: begin
        if (fit12) begin
          pack_inst = {in_imm[11:0], 5'd0, 3'b000, in_rd, OP_IMM};
        end else begin
          pack_inst = {lui_hi, in_rd, OP_LUI};
          enc_two   = |in_imm[11:0];
        end
      end
      default: enc_err = 2'b11;
    endcase
    enc_inst = (enc_err != 2'b00) ? NOP : pack_inst;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_inst  <= 32'd0;
      out_err   <= 2'b00;
      pend_rd   <= 5'd0;
      pend_imm  <= 12'd0;
    end else begin
      case (state)
        EMPTY, FULL: begin
          if (accept) begin
            state     <= enc_two ? FULL2 : FULL;
            out_valid <= 1'b1;
            out_inst  <= enc_inst;
            out_err   <= enc_err;
            pend_rd   <= in_rd;
            pend_imm  <= in_imm[11:0];
          end else if ((state == FULL) && out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        FULL2: begin
          if (out_ready) begin
            state    <= FULL;
            out_inst <= {pend_imm, pend_rd, 3'b000, pend_rd, OP_IMM};
            out_err  <= 2'b00;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed vectors plus a randomized request stream
// scored against a queue-based reference of expected output beats.
module tb_imm_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [1:0]  out_err;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int n_beats  = 0;
  logic rand_rdy = 1'b0;
  logic [33:0] exp_q[$];

  imm_encoder dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: list of {err, inst} beats one request must produce
  task automatic model_push(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] imm);
    longint v;
    logic [31:0] hi;
    logic r;
    logic a;
    v = longint'($signed(imm));
    a = imm[0];
    case (f)
      3'd0: begin
        if (!(op == 7'b0000011 || op == 7'b0010011 || op == 7'b1100111))
          exp_q.push_back({2'b11, 32'h13});
        else if (v < -2048 || v > 2047)
          exp_q.push_back({2'b01, 32'h13});
        else
          exp_q.push_back({2'b00, imm[11:0], rs1, f3, rd, op});
      end
      3'd1: begin
        if (v < -2048 || v > 2047) exp_q.push_back({2'b01, 32'h13});
        else exp_q.push_back({2'b00, imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011});
      end
      3'd2: begin
        r = (v < -4096 || v > 4094);
        if (r || a) exp_q.push_back({a, r, 32'h13});
        else exp_q.push_back({2'b00, imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011});
      end
      3'd3: begin
        r = (v < -1048576 || v > 1048574);
        if (r || a) exp_q.push_back({a, r, 32'h13});
        else exp_q.push_back({2'b00, imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111});
      end
      3'd4: begin
        if (v >= -2048 && v <= 2047) begin
          exp_q.push_back({2'b00, imm[11:0], 5'd0, 3'b000, rd, 7'b0010011});
        end else begin
          hi = (imm + 32'h800) >> 12;
          exp_q.push_back({2'b00, hi[19:0], rd, 7'b0110111});
          if (imm[11:0] != 12'd0)
            exp_q.push_back({2'b00, imm[11:0], rd, 3'b000, rd, 7'b0010011});
        end
      end
      default: exp_q.push_back({2'b11, 32'h13});
    endcase
  endtask

  // scoreboard: inputs and out_ready change only just after posedge, so the
  // negedge sees exactly what the next posedge will act on
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        n_beats++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          logic [33:0] e;
          e = exp_q.pop_front();
          check("beat_inst", {32'd0, out_inst}, {32'd0, e[31:0]});
          check("beat_err", {62'd0, out_err}, {62'd0, e[33:32]});
        end
      end
      if (in_valid && in_ready)
        model_push(in_fmt, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  // driver: present a request and hold it until the cycle it is taken
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm);
    logic acc;
    int n;
    in_valid = 1'b1; in_fmt = f; in_opcode = op; in_funct3 = f3;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("send_timeout", 64'd1, 64'd0);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int bnd[10] = '{-2048, 2047, -2049, 2048, -4096, 4094, 4095, -1048576, 1048574, 1048576};
  logic [6:0] ops[4] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0110011};

  initial begin
    logic [31:0] held_inst;
    logic [1:0]  held_err;
    int k;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_fmt = '0; in_opcode = '0; in_funct3 = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    #12;
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_inst", {32'd0, out_inst}, 64'd0);
    check("rst_err", {62'd0, out_err}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // I-type ADDI x1, x2, -1
    out_ready = 1'b1;
    send(3'd0, 7'b0010011, 3'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF);
    check("i_valid", {63'd0, out_valid}, 64'd1);
    check("i_inst", {32'd0, out_inst}, 64'hFFF10093);
    check("i_err", {62'd0, out_err}, 64'd0);

    // branch: good, misaligned, out of range
    send(3'd2, 7'd0, 3'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    check("b_inst", {32'd0, out_inst}, 64'h00208463);
    check("b_err", {62'd0, out_err}, 64'd0);
    send(3'd2, 7'd0, 3'd0, 5'd0, 5'd1, 5'd2, 32'd3);
    check("b_mis_inst", {32'd0, out_inst}, 64'h13);
    check("b_mis_err", {62'd0, out_err}, 64'd2);
    send(3'd2, 7'd0, 3'd0, 5'd0, 5'd1, 5'd2, 32'd4096);
    check("b_rng_err", {62'd0, out_err}, 64'd1);

    // LI, two beats then LUI only
    send(3'd4, 7'd0, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345678);
    check("li_lui", {32'd0, out_inst}, 64'h123452B7);
    check("li_ready_lui", {63'd0, in_ready}, 64'd0);
    idle(1);
    check("li_addi", {32'd0, out_inst}, 64'h67828293);
    send(3'd4, 7'd0, 3'd0, 5'd5, 5'd0, 5'd0, 32'h00001000);
    check("li_lui_only", {32'd0, out_inst}, 64'h000012B7);
    idle(1);
    check("li_single_beat", {63'd0, out_valid}, 64'd0);

    // invalid format
    send(3'd6, 7'd0, 3'd0, 5'd3, 5'd4, 5'd5, 32'd1);
    check("inv_inst", {32'd0, out_inst}, 64'h13);
    check("inv_err", {62'd0, out_err}, 64'd3);
    idle(1);
    check("inv_one_beat", {63'd0, out_valid}, 64'd0);

    // backpressure hold
    out_ready = 1'b0;
    send(3'd1, 7'd0, 3'd2, 5'd0, 5'd7, 5'd9, 32'hFFFF_F800);
    held_inst = out_inst;
    held_err = out_err;
    check("bp_inst_sw", {32'd0, out_inst}, {32'd0, 7'b1000000, 5'd9, 5'd7, 3'd2, 5'd0, 7'b0100011});
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("bp_valid", {63'd0, out_valid}, 64'd1);
      check("bp_inst", {32'd0, out_inst}, {32'd0, held_inst});
      check("bp_err", {62'd0, out_err}, {62'd0, held_err});
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    idle(2);

    // reset while the LUI beat is held with ADDI pending
    out_ready = 1'b0;
    send(3'd4, 7'd0, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345678);
    check("rr_lui", {32'd0, out_inst}, 64'h123452B7);
    idle(1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rr_valid", {63'd0, out_valid}, 64'd0);
    check("rr_inst", {32'd0, out_inst}, 64'd0);
    exp_q.delete();
    idle(1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("rr_no_addi", {63'd0, out_valid}, 64'd0);
    end

    // randomized stream with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] imm;
      k = $urandom_range(0, 4);
      case (k)
        0: imm = 32'($urandom_range(0, 4200)) - 32'd2100;
        1: imm = 32'(bnd[$urandom_range(0, 9)]);
        2: imm = 32'($urandom_range(0, 2200000)) - 32'd1100000;
        default: imm = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) imm[0] = 1'b0;
      send(3'($urandom_range(0, 7)), ops[$urandom_range(0, 3)], 3'($urandom_range(0, 7)),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), imm);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      idle(1);
      k++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    idle(2);
    check("drain_idle", {63'd0, out_valid}, 64'd0);
    check("beats_seen_nonzero", {63'd0, (n_beats > 400)}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
